shift_count_register: RTL
=========================

# shift_count_register

Parametrised successor to the fixed 8-bit clear/enable data register. It stores a WIDTH-bit word and, under a 3-bit mode code, can hold, parallel-load, increment, decrement, shift or rotate it. A registered carry/borrow flag and a zero flag come with the word. It serves as the CPU's accumulator, program counter and shift register from one design, replacing the chained 4-bit register pairs.

## Interface
- WIDTH, 8, data width in bits; legal range 2..32.
- RESET_VALUE, 0, value loaded into q by clear; WIDTH bits.
- clock  input  1  single clock; all state updates on rising edge.
- clear  input  1  reset; asynchronous, active-high.
- clock_enable  input  1  when low, all state holds regardless of mode.
- mode  input  3  operation select, sampled at rising edge.
- d  input  WIDTH  parallel load data.
- serial_in  input  1  bit shifted in by shift modes.
- q  output  WIDTH  registered word.
- carry  output  1  registered carry/borrow/shifted-out bit.
- zero  output  1  combinational, high when q == 0.

## Operation
- clear high: q = RESET_VALUE, carry = 0 immediately, with no clock needed. Overrides clock_enable and mode for as long as it is held.
- clear low, clock_enable low: q and carry hold.
- clear low, clock_enable high, rising edge, by mode:
  - 0 HOLD: q and carry unchanged.
  - 1 LOAD: q = d; carry = 0.
  - 2 INC: q = q + 1 mod 2^WIDTH; carry = 1 only when old q is all-ones (wrap), else 0.
  - 3 DEC: q = q - 1 mod 2^WIDTH; carry = 1 only when old q is 0 (borrow), else 0.
  - 4 SHL: q = {q[WIDTH-2:0], serial_in}; carry = old q[WIDTH-1].
  - 5 SHR: q = {serial_in, q[WIDTH-1:1]}; carry = old q[0].
  - 6 ROL: q = {q[WIDTH-2:0], q[WIDTH-1]}; carry = old q[WIDTH-1].
  - 7 ROR: q = {q[0], q[WIDTH-1:1]}; carry = old q[0].
- Arithmetic is unsigned, modulo 2^WIDTH, and never saturates.
- No internal state beyond q and carry; no multi-cycle operations.
- zero is derived from q only, never from carry.

## Timing
- Reset values: q = RESET_VALUE, carry = 0, zero = (RESET_VALUE == 0).
- Latency is one cycle for every mode: the result is visible on q and carry right after the rising edge where the mode was sampled.
- zero follows q within the same cycle, with no extra register stage.
- clear asserted between edges changes q and carry at once, without waiting for an edge.
- clear deasserted: the first rising edge with clear low performs the sampled mode normally. No dead cycle is inserted.
- clear asserted on the same edge as any mode: clear wins and the mode is discarded.
- Back-to-back operations are allowed every cycle with no restrictions.
- mode, d and serial_in must be stable around the rising edge only. Their values are don't-care while clock_enable is low or clear is high.

## Test plan
- Reset (WIDTH=8, RESET_VALUE=8'h5A): assert clear mid-cycle with clock_enable=1, mode=INC -> q=8'h5A, carry=0, zero=0 immediately and for every edge while clear is held; deassert -> next edge q=8'h5B.
- Load and enable gating: LOAD d=8'hC3 -> q=8'hC3, carry=0; then clock_enable=0, mode=INC for 3 edges -> q stays 8'hC3.
- Increment wrap: load 8'hFE, INC twice -> q=8'hFF, carry=0, then q=8'h00, carry=1, zero=1; INC again -> q=8'h01, carry=0.
- Decrement borrow: load 8'h01, DEC twice -> q=8'h00, zero=1, carry=0, then q=8'hFF, carry=1, zero=0.
- Shifts: load 8'b1000_0001; SHL serial_in=0 -> q=8'b0000_0010, carry=1; SHR serial_in=1 -> q=8'b1000_0001, carry=0; ROR -> q=8'b1100_0000, carry=1; ROL -> q=8'b1000_0001, carry=1.
- HOLD keeps carry, and width generality: after INC wrap (carry=1), HOLD 2 edges -> carry stays 1. Repeat the wrap test with WIDTH=4, RESET_VALUE=0: load 4'hF, INC -> q=4'h0, carry=1.

Source files
------------

// File: rtl/shift_count_register.sv
// Accumulator / program counter / shift register: hold, load, inc, dec, shift, rotate; 1-cycle latency.
// No backpressure: clock_enable low freezes q and carry; clear is asynchronous and overrides everything.
module shift_count_register #(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             clock_enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_INC  = 3'd2,
    MODE_DEC  = 3'd3,
    MODE_SHL  = 3'd4,
    MODE_SHR  = 3'd5,
    MODE_ROL  = 3'd6,
    MODE_ROR  = 3'd7
  } mode_t;

  logic [WIDTH-1:0] q_nxt;
  logic             carry_nxt;

  always_comb begin
    q_nxt     = q;
    carry_nxt = carry;
    case (mode_t'(mode))
      MODE_HOLD: begin
        q_nxt     = q;
        carry_nxt = carry;
      end
      MODE_LOAD: begin
        q_nxt     = d;
        carry_nxt = 1'b0;
      end
      // Carry out of the WIDTH+1 bit sum is exactly the all-ones wrap.
      MODE_INC: {carry_nxt, q_nxt} = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
      MODE_DEC: begin
        q_nxt     = q - {{(WIDTH-1){1'b0}}, 1'b1};
        carry_nxt = (q == '0);
      end
      MODE_SHL: begin
        q_nxt     = {q[WIDTH-2:0], serial_in};
        carry_nxt = q[WIDTH-1];
      end
      MODE_SHR: begin
        q_nxt     = {serial_in, q[WIDTH-1:1]};
        carry_nxt = q[0];
      end
      MODE_ROL: begin
        q_nxt     = {q[WIDTH-2:0], q[WIDTH-1]};
        carry_nxt = q[WIDTH-1];
      end
      MODE_ROR: begin
        q_nxt     = {q[0], q[WIDTH-1:1]};
        carry_nxt = q[0];
      end
      default: begin
        q_nxt     = q;
        carry_nxt = carry;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      q     <= RESET_VALUE;
      carry <= 1'b0;
    end else if (clock_enable) begin
      q     <= q_nxt;
      carry <= carry_nxt;
    end
  end

  assign zero = (q == '0);

endmodule
